// File: rtl/wwm_projectile_ctrl.sv
// Projectile sequencer: latches launch velocity on Fire, steps a fixed-point position once per frame
// under gravity, and reports hit/miss. Define WWM_WIND_EN to add a signed wind input that nudges vx.
module wwm_projectile_ctrl #(
    parameter logic [9:0] LAUNCH_X = 10'd170,
    parameter logic [9:0] LAUNCH_Y = 10'd460,
    parameter int         FRAC     = 4,
    parameter int         VEL_W    = 10,
    parameter int         GRAVITY  = 3,
    parameter int         TGT_XL   = 650,
    parameter int         TGT_XH   = 675,
    parameter int         TGT_YL   = 470,
    parameter int         TGT_YH   = 475
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic                    frame_tick,
    input  logic                    Fire,
    input  logic signed [VEL_W-1:0] vx_init,
    input  logic signed [VEL_W-1:0] vy_init,
`ifdef WWM_WIND_EN
    input  logic signed [3:0]       wind,
`endif
    output logic [9:0]              projectileCenterX,
    output logic [9:0]              projectileCenterY,
    output logic                    busy,
    output logic                    hit,
    output logic                    miss
);

    localparam int INT_W = 12;
    localparam int POS_W = INT_W + FRAC;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FLIGHT = 2'd1;
    localparam logic [1:0] S_STEP   = 2'd2;
    localparam logic [1:0] S_CHECK  = 2'd3;

    localparam logic signed [INT_W-1:0] HIT_XL   = INT_W'(TGT_XL);
    localparam logic signed [INT_W-1:0] HIT_XH   = INT_W'(TGT_XH);
    localparam logic signed [INT_W-1:0] HIT_YL   = INT_W'(TGT_YL);
    localparam logic signed [INT_W-1:0] HIT_YH   = INT_W'(TGT_YH);
    localparam logic signed [INT_W-1:0] MISS_XHI = 12'sd775;
    localparam logic signed [INT_W-1:0] MISS_XLO = 12'sd160;
    localparam logic signed [INT_W-1:0] MISS_YHI = 12'sd475;
    localparam logic signed [INT_W-1:0] MISS_YLO = 12'sd50;

    localparam logic signed [VEL_W:0] VEL_MIN_X = {2'b11, {(VEL_W-1){1'b0}}};
    localparam logic signed [VEL_W:0] GRAV_X    = (VEL_W+1)'(GRAVITY);

    localparam logic signed [POS_W-1:0] LAUNCH_X_FP = {2'b00, LAUNCH_X, {FRAC{1'b0}}};
    localparam logic signed [POS_W-1:0] LAUNCH_Y_FP = {2'b00, LAUNCH_Y, {FRAC{1'b0}}};

    logic [1:0]              state_q, state_d;
    logic signed [POS_W-1:0] pos_x_q, pos_x_d;
    logic signed [POS_W-1:0] pos_y_q, pos_y_d;
    logic signed [VEL_W-1:0] vx_q, vx_d;
    logic signed [VEL_W-1:0] vy_q, vy_d;
    logic                    hit_q, hit_d;
    logic                    miss_q, miss_d;

    logic signed [POS_W-1:0] vx_ext, vy_ext;
    logic signed [VEL_W:0]   vy_grav;
    logic signed [VEL_W-1:0] vy_step;
    logic signed [VEL_W-1:0] vx_step;
    logic signed [INT_W-1:0] x_int, y_int;
    logic                    in_box, out_field;

    assign vx_ext  = $signed({{(POS_W-VEL_W){vx_q[VEL_W-1]}}, vx_q});
    assign vy_ext  = $signed({{(POS_W-VEL_W){vy_q[VEL_W-1]}}, vy_q});
    assign vy_grav = $signed({vy_q[VEL_W-1], vy_q}) - GRAV_X;
    assign vy_step = (vy_grav < VEL_MIN_X) ? VEL_MIN_X[VEL_W-1:0] : vy_grav[VEL_W-1:0];

`ifdef WWM_WIND_EN
    localparam logic signed [VEL_W:0] VEL_MAX_X = {2'b00, {(VEL_W-1){1'b1}}};
    logic signed [VEL_W:0] vx_wind;
    assign vx_wind = $signed({vx_q[VEL_W-1], vx_q}) + $signed({{(VEL_W-3){wind[3]}}, wind});
    assign vx_step = (vx_wind < VEL_MIN_X) ? VEL_MIN_X[VEL_W-1:0] :
                     (vx_wind > VEL_MAX_X) ? VEL_MAX_X[VEL_W-1:0] : vx_wind[VEL_W-1:0];
`else
    assign vx_step = vx_q;
`endif

    // Integer pixel part is kept signed and 12 bits wide so off-screen overshoot never wraps.
    assign x_int     = pos_x_q[POS_W-1:FRAC];
    assign y_int     = pos_y_q[POS_W-1:FRAC];
    assign in_box    = (x_int >= HIT_XL) && (x_int <= HIT_XH) && (y_int >= HIT_YL) && (y_int <= HIT_YH);
    assign out_field = (x_int >= MISS_XHI) || (x_int <= MISS_XLO) ||
                       (y_int >= MISS_YHI) || (y_int <= MISS_YLO);

    always_comb begin
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Fire) begin
                    state_d = S_FLIGHT;
                    vx_d    = vx_init;
                    vy_d    = vy_init;
                    pos_x_d = LAUNCH_X_FP;
                    pos_y_d = LAUNCH_Y_FP;
                end
            end
            S_FLIGHT: begin
                if (frame_tick) state_d = S_STEP;
            end
            S_STEP: begin
                // Screen Y grows downward while vy is positive-up, hence the subtraction.
                pos_x_d = pos_x_q + vx_ext;
                pos_y_d = pos_y_q - vy_ext;
                vy_d    = vy_step;
                vx_d    = vx_step;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (in_box) begin
                    hit_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (out_field) begin
                    miss_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FLIGHT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outcome pulses are registered: tick sampled at edge n, position updates at n+1, pulse at n+2.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            pos_x_q <= LAUNCH_X_FP;
            pos_y_q <= LAUNCH_Y_FP;
            vx_q    <= '0;
            vy_q    <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    assign projectileCenterX = pos_x_q[FRAC+9:FRAC];
    assign projectileCenterY = pos_y_q[FRAC+9:FRAC];
    assign busy              = (state_q != S_IDLE);
    assign hit               = hit_q;
    assign miss              = miss_q;

endmodule

// File: tb/tb_wwm_projectile_ctrl.sv
// Directed bench for wwm_projectile_ctrl: reset, gravity drop, flat shot to the right edge,
// target hit on the Y=475 boundary, and Fire/frame_tick overlap during a step.
module tb_wwm_projectile_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_tick;
    logic       fire;
    logic signed [9:0] vx_init;
    logic signed [9:0] vy_init;
`ifdef WWM_WIND_EN
    logic signed [3:0] wind = 4'sd0;
`endif
    logic [9:0] px, py;
    logic       busy, hit, miss;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    wwm_projectile_ctrl dut (
        .clk               (clk),
        .Reset             (reset_n),
        .frame_tick        (frame_tick),
        .Fire              (fire),
        .vx_init           (vx_init),
        .vy_init           (vy_init),
`ifdef WWM_WIND_EN
        .wind              (wind),
`endif
        .projectileCenterX (px),
        .projectileCenterY (py),
        .busy              (busy),
        .hit               (hit),
        .miss              (miss)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Accepted tick: edge to STEP, edge to CHECK (position updated), edge where outcome registers.
    task automatic frame(output logic h, output logic m);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
        cyc();
        h = hit;
        m = miss;
    endtask

    task automatic launch(input int vx, input int vy);
        vx_init = 10'(vx);
        vy_init = 10'(vy);
        fire    = 1'b1;
        cyc();
        fire    = 1'b0;
    endtask

    function automatic int floor16(input int v);
        return (v >= 0) ? v / 16 : -((-v + 15) / 16);
    endfunction

    initial begin
        logic h, m;
        int   pulses;
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        fire       = 1'b0;
        vx_init    = '0;
        vy_init    = '0;
        cyc();
        cyc();

        check("rst_x", 32'(px), 32'd170);
        check("rst_y", 32'(py), 32'd460);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_miss", 32'(miss), 32'd0);
        reset_n = 1'b1;
        cyc();

        // Reset mid-flight after 3 frames at 1 px/frame.
        launch(16, 0);
        check("launch_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 3; k++) frame(h, m);
        check("mid_x", 32'(px), 32'd173);
        reset_n = 1'b0;
        #1;
        check("abort_x", 32'(px), 32'd170);
        check("abort_y", 32'(py), 32'd460);
        check("abort_busy", 32'(busy), 32'd0);
        cyc();
        reset_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (hit || miss) pulses++;
        end
        check("abort_pulses", 32'(pulses), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);

        // Gravity drop: vy=0, vy falls -3,-6,...; Y offset after k ticks = 3k(k-1)/2 sixteenths.
        launch(0, 0);
        pulses = 0;
        for (int k = 1; k <= 14; k++) begin
            frame(h, m);
            check($sformatf("drop_y_%0d", k), 32'(py), 32'(460 + (3 * k * (k - 1) / 2) / 16));
            check($sformatf("drop_x_%0d", k), 32'(px), 32'd170);
            check($sformatf("drop_miss_%0d", k), 32'(m), (k == 14) ? 32'd1 : 32'd0);
            check($sformatf("drop_hit_%0d", k), 32'(h), 32'd0);
            if (h || m) pulses++;
        end
        check("drop_busy_end", 32'(busy), 32'd0);
        cyc();
        check("drop_pulse_width", 32'(miss), 32'd0);
        check("drop_pulses", 32'(pulses), 32'd1);
        check("drop_hold_y", 32'(py), 32'd477);

        // Flat-ish shot at 30 px/frame, vy=30: passes X=650 with Y=452, exits at X=800.
        launch(480, 30);
        for (int k = 1; k <= 21; k++) begin
            frame(h, m);
            check($sformatf("shot_x_%0d", k), 32'(px), 32'(170 + 30 * k));
            check($sformatf("shot_y_%0d", k), 32'(py),
                  32'(460 + floor16(-30 * k + 3 * k * (k - 1) / 2)));
            check($sformatf("shot_miss_%0d", k), 32'(m), (k == 21) ? 32'd1 : 32'd0);
            check($sformatf("shot_hit_%0d", k), 32'(h), 32'd0);
        end
        check("shot_busy_end", 32'(busy), 32'd0);

        // Lands at (660,475): Y=475 is both a miss threshold and the target's lower edge -> hit.
        cyc();
        launch(490, 7);
        for (int k = 1; k <= 16; k++) begin
            frame(h, m);
            check($sformatf("tgt_x_%0d", k), 32'(px), 32'(170 + (490 * k) / 16));
            check($sformatf("tgt_y_%0d", k), 32'(py),
                  32'(460 + floor16(-7 * k + 3 * k * (k - 1) / 2)));
            check($sformatf("tgt_hit_%0d", k), 32'(h), (k == 16) ? 32'd1 : 32'd0);
            check($sformatf("tgt_miss_%0d", k), 32'(m), 32'd0);
        end
        check("tgt_busy_end", 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) cyc();
        check("tgt_hit_low", 32'(hit), 32'd0);
        check("tgt_hold_x", 32'(px), 32'd660);
        check("tgt_hold_y", 32'(py), 32'd475);

        // Fire held through flight and frame_tick held across STEP and CHECK.
        launch(16, 0);
        fire       = 1'b1;
        vx_init    = 10'sd200;
        frame_tick = 1'b1;
        cyc();
        cyc();
        check("ovl_x_step", 32'(px), 32'd171);
        cyc();
        frame_tick = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        check("ovl_x_hold", 32'(px), 32'd171);
        check("ovl_busy", 32'(busy), 32'd1);
        frame(h, m);
        check("ovl_x_next", 32'(px), 32'd172);
        check("ovl_no_pulse", 32'(h | m), 32'd0);
        fire    = 1'b0;
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
